// File: rtl/timer_capture_pkg.sv
// Shared types for the input-capture stage: edge selection and the FIFO entry layout.
package timer_capture_pkg;

  localparam int CAP_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;

  typedef struct packed {
    logic [CAP_WIDTH_DEFAULT-1:0] timestamp;
    logic                         rising;
  } cap_entry_t;

  function automatic logic edge_selected(input edge_sel_e sel, input logic rise, input logic fall);
    logic hit;
    case (sel)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/timer_capture_fifo.sv
// First-word-fall-through FIFO of capture entries; head, level and flags are all registered.
module capture_fifo
  import timer_capture_pkg::*;
#(
  parameter type entry_t = cap_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   wr_data,
  output entry_t                   rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  entry_t             mem_r [DEPTH];
  entry_t             head_r;
  entry_t             head_nxt_s;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   rd_nxt_s;
  logic [LVL_W-1:0]   level_r;
  logic [LVL_W-1:0]   level_nxt_s;
  logic [LVL_W-1:0]   remain_s;
  logic               empty_r;
  logic               full_r;
  logic               pop_ok_s;
  logic               push_ok_s;

  // Next-state: a full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop_ok_s    = pop & ~empty_r;
    push_ok_s   = push & (~full_r | pop_ok_s);
    rd_nxt_s    = rd_ptr_r + PTR_W'(pop_ok_s);
    remain_s    = level_r - LVL_W'(pop_ok_s);
    level_nxt_s = level_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_nxt_s = level_r + {{(LVL_W-1){1'b0}}, 1'b1};
      2'b01:   level_nxt_s = level_r - {{(LVL_W-1){1'b0}}, 1'b1};
      default: level_nxt_s = level_r;
    endcase
    // The head keeps its last value once the FIFO drains.
    if (remain_s != {LVL_W{1'b0}}) begin
      head_nxt_s = mem_r[rd_nxt_s];
    end else if (push_ok_s) begin
      head_nxt_s = wr_data;
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, level, flags and registered head.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      head_r   <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      rd_ptr_r <= rd_nxt_s;
      level_r  <= level_nxt_s;
      empty_r  <= (level_nxt_s == {LVL_W{1'b0}});
      full_r   <= (level_nxt_s == LVL_W'(DEPTH));
      head_r   <= head_nxt_s;
    end
  end

  assign rd_data = head_r;
  assign level   = level_r;
  assign full    = full_r;
  assign empty   = empty_r;

endmodule

// File: rtl/timer_capture.sv
// Input capture: synchronise and filter cap_in, timestamp selected edges with cnt_value,
// queue them in a FWFT FIFO and raise interrupt / sticky overflow.
module timer_capture
  import timer_capture_pkg::*;
#(
  parameter int COUNTER_SIZE = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 0
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic                          cap_in,
  input  logic [COUNTER_SIZE-1:0]       cnt_value,
  input  logic                          cap_en,
  input  logic [1:0]                    edge_sel,
  input  logic                          int_en,
  input  logic                          rd_en,
  input  logic                          ovf_clr,
  output logic [COUNTER_SIZE-1:0]       cap_data,
  output logic                          cap_edge,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          cap_int
);

  localparam int FCNT_W = (FILTER_LEN > 0) ? $clog2(FILTER_LEN + 1) : 1;

  typedef struct packed {
    logic [COUNTER_SIZE-1:0] timestamp;
    logic                    rising;
  } entry_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic                   filt_r;
  logic                   filt_d_r;
  logic [FCNT_W-1:0]      fcnt_r;
  logic                   rise_s;
  logic                   fall_s;
  logic                   push_req_s;
  logic                   pop_s;
  logic                   drop_s;
  logic                   push_s;
  logic                   overflow_r;
  logic                   cap_int_r;
  entry_t                 entry_s;
  entry_t                 head_s;

  // Metastability synchroniser on the asynchronous pin.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], cap_in};
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Level filter: a new level must persist FILTER_LEN+1 cycles; runs regardless of cap_en.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      filt_r   <= 1'b0;
      filt_d_r <= 1'b0;
      fcnt_r   <= {FCNT_W{1'b0}};
    end else begin
      filt_d_r <= filt_r;
      if (sync_s == filt_r) begin
        fcnt_r <= {FCNT_W{1'b0}};
      end else if (fcnt_r == FCNT_W'(FILTER_LEN)) begin
        filt_r <= sync_s;
        fcnt_r <= {FCNT_W{1'b0}};
      end else begin
        fcnt_r <= fcnt_r + {{(FCNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Edge qualification and FIFO handshake; a drop only happens when no pop frees a slot.
  always_comb begin
    rise_s             = filt_r & ~filt_d_r;
    fall_s             = ~filt_r & filt_d_r;
    push_req_s         = cap_en & edge_selected(edge_sel_e'(edge_sel), rise_s, fall_s);
    pop_s              = rd_en & ~fifo_empty;
    drop_s             = push_req_s & fifo_full & ~pop_s;
    push_s             = push_req_s & ~drop_s;
    entry_s.timestamp  = cnt_value;
    entry_s.rising     = rise_s;
  end

  // Sticky overflow (a new drop beats a clear) and the one-cycle-lagging interrupt.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      overflow_r <= 1'b0;
      cap_int_r  <= 1'b0;
    end else begin
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr) begin
        overflow_r <= 1'b0;
      end
      cap_int_r <= int_en & (~fifo_empty | overflow_r);
    end
  end

  capture_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (entry_s),
    .rd_data (head_s),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cap_data = head_s.timestamp;
  assign cap_edge = head_s.rising;
  assign overflow = overflow_r;
  assign cap_int  = cap_int_r;

endmodule

// File: tb/tb_timer_capture.sv
// Directed bench for timer_capture: one instance without filter, one with FILTER_LEN=3.
module tb_timer_capture;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        cap_in = 1'b0;
  logic [31:0] cnt_value = 32'd0;
  logic        cap_en = 1'b0;
  logic [1:0]  edge_sel = 2'b00;
  logic        int_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        ovf_clr = 1'b0;

  logic [31:0] cap_data0, cap_data3;
  logic        cap_edge0, cap_edge3;
  logic        empty0, empty3, full0, full3;
  logic [2:0]  level0, level3;
  logic        ovf0, ovf3, int0, int3;

  int n_cmp = 0;
  int n_err = 0;
  int edge_no = 0;

  always #5 clk = ~clk;

  timer_capture #(.COUNTER_SIZE(32), .FIFO_DEPTH(4), .SYNC_STAGES(2), .FILTER_LEN(0)) dut0 (
    .clk(clk), .rst_b(rst_b), .cap_in(cap_in), .cnt_value(cnt_value), .cap_en(cap_en),
    .edge_sel(edge_sel), .int_en(int_en), .rd_en(rd_en), .ovf_clr(ovf_clr),
    .cap_data(cap_data0), .cap_edge(cap_edge0), .fifo_empty(empty0), .fifo_full(full0),
    .level(level0), .overflow(ovf0), .cap_int(int0)
  );

  timer_capture #(.COUNTER_SIZE(32), .FIFO_DEPTH(4), .SYNC_STAGES(2), .FILTER_LEN(3)) dut3 (
    .clk(clk), .rst_b(rst_b), .cap_in(cap_in), .cnt_value(cnt_value), .cap_en(cap_en),
    .edge_sel(edge_sel), .int_en(int_en), .rd_en(rd_en), .ovf_clr(ovf_clr),
    .cap_data(cap_data3), .cap_edge(cap_edge3), .fifo_empty(empty3), .fifo_full(full3),
    .level(level3), .overflow(ovf3), .cap_int(int3)
  );

  // After each rising edge: outputs settle, cnt_value advances so that edge k samples k.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_no   = edge_no + 1;
    cnt_value = 32'(edge_no + 1);
  endtask

  task automatic goto(input int e);
    while (edge_no < e) tick();
  endtask

  task automatic restart();
    rst_b = 1'b0; cap_in = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
    cap_en = 1'b0; edge_sel = 2'b00; int_en = 1'b0;
    tick();
    rst_b     = 1'b1;
    edge_no   = 0;
    cnt_value = 32'd1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------- reset state and rising capture ----------
    restart();
    chk("rst_empty0", 64'(empty0), 64'd1);
    chk("rst_full0", 64'(full0), 64'd0);
    chk("rst_level0", 64'(level0), 64'd0);
    chk("rst_data0", 64'(cap_data0), 64'd0);
    chk("rst_edge0", 64'(cap_edge0), 64'd0);
    chk("rst_ovf0", 64'(ovf0), 64'd0);
    chk("rst_int0", 64'(int0), 64'd0);
    chk("rst_empty3", 64'(empty3), 64'd1);
    chk("rst_level3", 64'(level3), 64'd0);
    edge_sel = 2'b01; cap_en = 1'b1; int_en = 1'b1;
    goto(9);  cap_in = 1'b1;
    goto(12); chk("rise_not_yet", 64'(empty0), 64'd1);
    goto(13);
    chk("rise_level", 64'(level0), 64'd1);
    chk("rise_data", 64'(cap_data0), 64'd13);
    chk("rise_edge", 64'(cap_edge0), 64'd1);
    chk("rise_int_lag", 64'(int0), 64'd0);
    goto(14); chk("rise_int", 64'(int0), 64'd1);

    // ---------- glitch rejection, FILTER_LEN=3 ----------
    restart();
    edge_sel = 2'b11; cap_en = 1'b1;
    goto(9);  cap_in = 1'b1;
    goto(11); cap_in = 1'b0;
    goto(25); chk("glitch_rejected", 64'(level3), 64'd0);
    goto(29); cap_in = 1'b1;
    goto(35); cap_in = 1'b0;
    chk("filt_rise_not_yet", 64'(level3), 64'd0);
    goto(36);
    chk("filt_rise_level", 64'(level3), 64'd1);
    chk("filt_rise_data", 64'(cap_data3), 64'd36);
    chk("filt_rise_edge", 64'(cap_edge3), 64'd1);
    goto(42); chk("filt_fall_level", 64'(level3), 64'd2);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("filt_fall_data", 64'(cap_data3), 64'd42);
    chk("filt_fall_edge", 64'(cap_edge3), 64'd0);
    chk("filt_after_pop", 64'(level3), 64'd1);
    goto(60); chk("filt_no_extra", 64'(level3), 64'd1);

    // ---------- overflow ----------
    restart();
    edge_sel = 2'b01; cap_en = 1'b1; int_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      goto(100 * k - 4); cap_in = 1'b1;
      if (k == 5) chk("ovf_full_before_drop", 64'(full0), 64'd1);
      if (k == 5) chk("ovf_clear_before_drop", 64'(ovf0), 64'd0);
      goto(100 * k + 46); cap_in = 1'b0;
    end
    goto(550);
    chk("ovf_full", 64'(full0), 64'd1);
    chk("ovf_level", 64'(level0), 64'd4);
    chk("ovf_flag", 64'(ovf0), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_pop_data", 64'(cap_data0), 64'(100 * i));
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    chk("ovf_drained", 64'(empty0), 64'd1);
    chk("ovf_hold_data", 64'(cap_data0), 64'd400);
    chk("ovf_still_set", 64'(ovf0), 64'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_cleared", 64'(ovf0), 64'd0);

    // ---------- full boundary: push and pop together ----------
    restart();
    edge_sel = 2'b01; cap_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      goto(20 * k - 4); cap_in = 1'b1;
      goto(20 * k + 6); cap_in = 1'b0;
    end
    goto(90);
    chk("fb_full", 64'(full0), 64'd1);
    goto(96); cap_in = 1'b1;
    goto(99); rd_en = 1'b1;
    goto(100); rd_en = 1'b0;
    chk("fb_level", 64'(level0), 64'd4);
    chk("fb_full_kept", 64'(full0), 64'd1);
    chk("fb_no_ovf", 64'(ovf0), 64'd0);
    for (int i = 2; i <= 5; i++) begin
      chk("fb_order", 64'(cap_data0), 64'(20 * i));
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    chk("fb_empty", 64'(empty0), 64'd1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("fb_rd_empty_level", 64'(level0), 64'd0);
    chk("fb_rd_empty_flag", 64'(empty0), 64'd1);
    chk("fb_rd_empty_hold", 64'(cap_data0), 64'd100);

    // ---------- enable gating ----------
    restart();
    edge_sel = 2'b01; cap_en = 1'b0;
    goto(5);  cap_in = 1'b1;
    goto(8);  cap_in = 1'b0;
    goto(11); cap_in = 1'b1;
    goto(20); chk("gate_off", 64'(level0), 64'd0);
    cap_en = 1'b1;
    goto(30); chk("gate_no_spurious", 64'(level0), 64'd0);
    cap_in = 1'b0;
    goto(49); chk("gate_fall_ignored", 64'(level0), 64'd0);
    cap_in = 1'b1;
    goto(52); chk("gate_edge_not_yet", 64'(level0), 64'd0);
    goto(53);
    chk("gate_edge_level", 64'(level0), 64'd1);
    chk("gate_edge_data", 64'(cap_data0), 64'd53);

    // ---------- reset mid-operation ----------
    restart();
    edge_sel = 2'b01; cap_en = 1'b1; int_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      goto(20 * k - 4); cap_in = 1'b1;
      goto(20 * k + 6); cap_in = 1'b0;
    end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("mid_level3", 64'(level0), 64'd3);
    chk("mid_ovf", 64'(ovf0), 64'd1);
    goto(110); cap_in = 1'b1;
    goto(112); rst_b = 1'b0; cap_in = 1'b0;
    tick(); rst_b = 1'b1;
    chk("mid_rst_level", 64'(level0), 64'd0);
    chk("mid_rst_empty", 64'(empty0), 64'd1);
    chk("mid_rst_full", 64'(full0), 64'd0);
    chk("mid_rst_ovf", 64'(ovf0), 64'd0);
    chk("mid_rst_int", 64'(int0), 64'd0);
    chk("mid_rst_data", 64'(cap_data0), 64'd0);
    goto(130);
    chk("mid_no_stale", 64'(level0), 64'd0);
    chk("mid_no_int", 64'(int0), 64'd0);
    chk("mid_no_stale3", 64'(level3), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/timer_capture.md
Name: timer_capture

Overview:
- Input-capture stage downstream of the timer core.
- Consumes the core's synchronous counter value (sync_cnt) and timestamps filtered edges of an external asynchronous capture pin.
- Buffers the timestamps in a small first-word-fall-through FIFO, to be drained by the register/bus side.
- Raises a capture interrupt and a sticky overflow flag.

Parameters:
- COUNTER_SIZE, 32, width of the counter value and of captured data.
- FIFO_DEPTH, 4, number of capture entries; power of two, minimum 2.
- SYNC_STAGES, 2, synchroniser flops on cap_in; minimum 2.
- FILTER_LEN, 0, extra stable cycles required before a level change is accepted; 0 bypasses the filter.

Ports:
- clk  input  1  system clock
- rst_b  input  1  synchronous active-low reset
- cap_in  input  1  asynchronous external capture pin
- cnt_value  input  COUNTER_SIZE  counter value from the timer core (sync_cnt)
- cap_en  input  1  capture enable
- edge_sel  input  2  capture edge: 00 none, 01 rising, 10 falling, 11 both
- int_en  input  1  capture interrupt enable
- rd_en  input  1  pop head entry
- ovf_clr  input  1  clear overflow flag
- cap_data  output  COUNTER_SIZE  head entry timestamp
- cap_edge  output  1  head entry edge type: 1 rising, 0 falling
- fifo_empty  output  1  FIFO empty
- fifo_full  output  1  FIFO full
- level  output  $clog2(FIFO_DEPTH)+1  current entry count
- overflow  output  1  sticky: a capture was dropped
- cap_int  output  1  capture interrupt

Behaviour:
- Reset: one clock, sampled with rst_b=0 at a clk rising edge (synchronous, active-low).
  - FIFO emptied: fifo_empty=1, fifo_full=0, level=0.
  - cap_data=0, cap_edge=0, overflow=0, cap_int=0.
  - Synchroniser, filtered level and filter counter all cleared to 0.
  - Reset mid-operation discards all entries and any in-flight edge.
- Synchroniser:
  - SYNC_STAGES flops produce s.
- Filter:
  - Filtered level f, counter fcnt.
  - If s==f, fcnt clears to 0.
  - If s!=f and fcnt==FILTER_LEN, then f<=s and fcnt<=0; otherwise fcnt increments.
  - With FILTER_LEN=0, f follows s with one cycle of delay.
  - Pulses on s shorter than FILTER_LEN+1 cycles are rejected.
- Edge event:
  - Asserted for one cycle when f changes.
  - Rise = f 0->1, fall = f 1->0, qualified by edge_sel and cap_en.
  - With cap_en=0 the filter still tracks the pin, so enabling capture never creates a spurious edge.
  - After reset, a cap_in held high yields one rising edge.
- Latency:
  - A clean cap_in transition first sampled at clk edge N produces a push at edge N+SYNC_STAGES+FILTER_LEN+1.
  - The push stores cnt_value as sampled at that same edge, plus the edge type.
  - The entry is visible on cap_data/cap_edge from that edge onward (FWFT).
- FIFO:
  - cap_data/cap_edge show the head entry whenever fifo_empty=0; they hold their last value when empty.
  - Pop when rd_en=1 and fifo_empty=0; rd_en on empty is ignored with no error.
  - Push when full without a pop: the new capture is dropped, the FIFO contents are unchanged, and overflow<=1.
  - Simultaneous push and pop when full: both occur, level stays FIFO_DEPTH, overflow is unchanged.
  - Simultaneous push and pop when empty: push only, level becomes 1.
  - Pointers wrap modulo FIFO_DEPTH.
  - level is the registered count (0..FIFO_DEPTH); fifo_full = (level==FIFO_DEPTH).
- Overflow:
  - Cleared by ovf_clr.
  - If ovf_clr coincides with a new drop, set wins.
- Interrupt:
  - cap_int = int_en & (~fifo_empty | overflow), registered, so it lags by one cycle.
- Arithmetic:
  - Captured value is cnt_value copied verbatim; no arithmetic.
  - Counter wrap-around in the core is transparent to this block.

Decomposition:
- Package timer_capture_pkg holds:
  - edge_sel_e enum: EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH.
  - Typedef cap_entry_t, a struct of timestamp (COUNTER_SIZE) and edge bit, with a default width constant.
- One sub-module, capture_fifo: a parameterised FWFT FIFO of cap_entry_t with push/pop/level/full/empty.
- Synchroniser, filter and edge logic live in the top module.

Test Plan:
- Rising capture. Stimulus: FILTER_LEN=0, SYNC_STAGES=2, edge_sel=01, cap_en=1; cnt_value equals the cycle index; cap_in rises just before edge 10. Required: push at edge 13; cap_data=13, cap_edge=1, level=1; cap_int=1 at edge 14 with int_en=1.
- Glitch rejection. Stimulus: FILTER_LEN=3; cap_in high for 2 cycles, later high for 6 cycles. Required: first pulse yields no entry; second pulse yields exactly one rising and one falling entry with edge_sel=11.
- Overflow. Stimulus: FIFO_DEPTH=4, five rising edges at cnt_value 100, 200, 300, 400, 500, no reads. Required: fifo_full=1, overflow=1; pops return 100, 200, 300, 400 in order, then fifo_empty=1; ovf_clr then gives overflow=0.
- Full boundary. Stimulus: FIFO full, edge push and rd_en in the same cycle. Required: level stays 4, oldest entry removed, new timestamp at the tail, overflow=0. Also rd_en on an empty FIFO leaves level=0.
- Enable gating. Stimulus: cap_en=0 while cap_in toggles, then cap_en=1 with cap_in static high. Required: no entries at any point; the first entry appears only on the next real edge.
- Reset mid-operation. Stimulus: level=3, overflow=1, edge in flight; rst_b=0 for one clk. Required: level=0, fifo_empty=1, overflow=0, cap_int=0 from the reset edge; no stale entry afterwards.
